// File: rtl/iecdrv_sd_arb.sv
// Round-robin arbiter that lets NDRV drive requesters share one SD block channel.
// One transaction at a time: IDLE -> ISSUE -> BUSY -> RELEASE -> IDLE.
module iecdrv_sd_arb #(
  parameter int NDRV = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [32*NDRV-1:0]   req_lba,
  input  logic [6*NDRV-1:0]    req_blk_cnt,
  input  logic [NDRV-1:0]      req_rd,
  input  logic [NDRV-1:0]      req_wr,
  input  logic [8*NDRV-1:0]    req_buff_din,
  output logic [NDRV-1:0]      req_ack,
  output logic [NDRV-1:0]      grant,
  output logic [31:0]          sd_lba,
  output logic [5:0]           sd_blk_cnt,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  output logic [7:0]           sd_buff_din
);

  localparam int IW = (NDRV > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_sel;
  logic [IW-1:0]   r_last;
  logic [31:0]     r_lba;
  logic [5:0]      r_cnt;
  logic            r_rd;
  logic            r_wr;

  logic [NDRV-1:0] w_pending;
  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic            w_take;
  int              w_dist;
  int              w_best;
  logic [31:0]     w_lba;
  logic [5:0]      w_cnt;
  logic            w_pick_rd;
  logic            w_pick_wr;
  logic            w_ackable;
  logic            w_owned;

  assign w_pending = req_rd | req_wr;

  // Round-robin pick: smallest distance from (last+1) among pending drives, plus its request fields
  always_comb begin
    w_best    = NDRV;
    w_pick    = r_last;
    w_take    = 1'b0;
    w_dist    = 0;
    w_lba     = 32'd0;
    w_cnt     = 6'd0;
    w_pick_rd = 1'b0;
    w_pick_wr = 1'b0;
    for (int i = 0; i < NDRV; i++) begin
      w_dist = (i + NDRV - 1 - int'(r_last)) % NDRV;
      w_take = w_pending[i] && (w_dist < w_best);
      w_best = w_take ? w_dist : w_best;
      w_pick = w_take ? IW'(i) : w_pick;
    end
    w_found = (w_best < NDRV);
    for (int i = 0; i < NDRV; i++) begin
      w_lba     = (w_pick == IW'(i)) ? req_lba[32*i +: 32]   : w_lba;
      w_cnt     = (w_pick == IW'(i)) ? req_blk_cnt[6*i +: 6] : w_cnt;
      w_pick_rd = (w_pick == IW'(i)) ? req_rd[i]             : w_pick_rd;
      w_pick_wr = (w_pick == IW'(i)) ? req_wr[i]             : w_pick_wr;
    end
  end

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = w_found ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   w_next = sd_ack ? ST_BUSY : ST_ISSUE;
      ST_BUSY:    w_next = sd_ack ? ST_BUSY : ST_RELEASE;
      ST_RELEASE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Owner, address/count latch and host request strobes; write wins when both are pending
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sel  <= {IW{1'b0}};
      r_last <= IW'(NDRV - 1);
      r_lba  <= 32'd0;
      r_cnt  <= 6'd0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_sel  <= w_pick;
            r_last <= w_pick;
            r_lba  <= w_lba;
            r_cnt  <= w_cnt;
            r_wr   <= w_pick_wr;
            r_rd   <= w_pick_rd & ~w_pick_wr;
          end
        end
        ST_ISSUE: begin
          if (sd_ack) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_ackable = (r_state == ST_ISSUE) || (r_state == ST_BUSY);
  assign w_owned   = (r_state != ST_IDLE);

  // Zero-latency ack routing and data mux so host buffer strobes stay aligned
  always_comb begin
    req_ack     = {NDRV{1'b0}};
    grant       = {NDRV{1'b0}};
    sd_buff_din = 8'd0;
    for (int i = 0; i < NDRV; i++) begin
      req_ack[i]  = sd_ack & w_ackable & (r_sel == IW'(i));
      grant[i]    = w_owned & (r_sel == IW'(i));
      sd_buff_din = (w_owned && (r_sel == IW'(i))) ? req_buff_din[8*i +: 8] : sd_buff_din;
    end
  end

  assign sd_lba     = r_lba;
  assign sd_blk_cnt = r_cnt;
  assign sd_rd      = r_rd;
  assign sd_wr      = r_wr;

endmodule

// File: tb/tb_iecdrv_sd_arb.sv
// Scoreboard bench for iecdrv_sd_arb (NDRV=2): stimulus pushes expected grants,
// a monitor with a small phase model pops and checks each issued transaction.
module tb_iecdrv_sd_arb;

  logic        clk_sys;
  logic        reset;
  logic [63:0] req_lba;
  logic [11:0] req_blk_cnt;
  logic [1:0]  req_rd;
  logic [1:0]  req_wr;
  logic [15:0] req_buff_din;
  logic [1:0]  req_ack;
  logic [1:0]  grant;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_din;

  logic [31:0] lba0, lba1;
  logic [5:0]  cnt0, cnt1;
  logic [7:0]  buf0, buf1;

  assign req_lba      = {lba1, lba0};
  assign req_blk_cnt  = {cnt1, cnt0};
  assign req_buff_din = {buf1, buf0};

  iecdrv_sd_arb #(.NDRV(2)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req_lba(req_lba), .req_blk_cnt(req_blk_cnt),
    .req_rd(req_rd), .req_wr(req_wr), .req_buff_din(req_buff_din),
    .req_ack(req_ack), .grant(grant),
    .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_din(sd_buff_din)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  typedef struct {
    int          drv;
    bit          wr;
    logic [31:0] lba;
    logic [5:0]  cnt;
  } txn_t;

  txn_t exp_q[$];
  int chk_total = 0;
  int chk_pass  = 0;
  int done_cnt  = 0;
  int rd_post[2];
  int wr_post[2];
  bit hold[2];
  int pulse_req = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_total++;
    if (act === exp) chk_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    chk_total++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  task automatic push(input int d, input bit w, input logic [31:0] l, input logic [5:0] c);
    txn_t t;
    t.drv = d; t.wr = w; t.lba = l; t.cnt = c;
    exp_q.push_back(t);
  endtask

  // Requester model: sole driver of req_rd/req_wr; drops the served request on req_ack rise unless held
  initial begin
    logic [1:0] prev_ack;
    int rd_seen[2];
    int wr_seen[2];
    req_rd = 2'b00; req_wr = 2'b00; prev_ack = 2'b00;
    rd_seen[0] = 0; rd_seen[1] = 0; wr_seen[0] = 0; wr_seen[1] = 0;
    forever begin
      @(negedge clk_sys);
      for (int i = 0; i < 2; i++) begin
        if (req_ack[i] && !prev_ack[i] && !hold[i]) begin
          if (req_wr[i]) req_wr[i] = 1'b0;
          else           req_rd[i] = 1'b0;
        end
        prev_ack[i] = req_ack[i];
        if (rd_post[i] != rd_seen[i]) begin req_rd[i] = 1'b1; rd_seen[i] = rd_post[i]; end
        if (wr_post[i] != wr_seen[i]) begin req_wr[i] = 1'b1; wr_seen[i] = wr_post[i]; end
      end
    end
  end

  // Host model: acks 2 cycles after a request and holds ack 10 cycles; can pulse ack on demand
  initial begin
    int pulse_done;
    pulse_done = 0;
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) begin
        repeat (2) @(posedge clk_sys);
        #1 sd_ack = 1'b1;
        repeat (10) @(posedge clk_sys);
        #1 sd_ack = 1'b0;
      end else if (pulse_req != pulse_done) begin
        @(posedge clk_sys); #1 sd_ack = 1'b1;
        @(posedge clk_sys); #1 sd_ack = 1'b0;
        pulse_done++;
      end
    end
  end

  // Monitor: phase model advanced on rising edges, outputs compared on falling edges
  initial begin
    int m_ph, m_own;
    bit m_wr;
    txn_t t;
    logic [1:0] e_oh;
    m_ph = 0; m_own = 0; m_wr = 1'b0;
    forever begin
      @(posedge clk_sys);
      if (reset) m_ph = 0;
      else begin
        case (m_ph)
          1: if (sd_ack) m_ph = 2;
          2: if (!sd_ack) m_ph = 3;
          3: begin m_ph = 0; done_cnt++; end
          default: ;
        endcase
      end
      @(negedge clk_sys);
      if (m_ph == 0 && (sd_rd || sd_wr)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 64'd1, 64'd0);
          m_own = 0; m_wr = 1'b0;
        end else begin
          t = exp_q.pop_front();
          m_own = t.drv; m_wr = t.wr;
          chk("issue_grant", grant, 2'b01 << t.drv);
          chk("issue_wr", sd_wr, t.wr);
          chk("issue_rd", sd_rd, !t.wr);
          chk("issue_lba", sd_lba, t.lba);
          chk("issue_cnt", sd_blk_cnt, t.cnt);
        end
        m_ph = 1;
      end
      e_oh = 2'b01 << m_own;
      chk("cyc_rd", sd_rd, (m_ph == 1) && !m_wr);
      chk("cyc_wr", sd_wr, (m_ph == 1) && m_wr);
      chk("cyc_grant", grant, (m_ph != 0) ? e_oh : 2'b00);
      chk("cyc_req_ack", req_ack, ((m_ph == 1 || m_ph == 2) && sd_ack) ? e_oh : 2'b00);
      chk("cyc_buff", sd_buff_din, (m_ph == 0) ? 8'h00 : ((m_own == 0) ? buf0 : buf1));
    end
  end

  task automatic wait_done(input int n, input string nm);
    for (int c = 0; c < 400 && done_cnt < n; c++) @(negedge clk_sys);
    if (done_cnt < n) fail_now(nm);
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk_sys); #1 reset = 1'b1;
    repeat (n) @(posedge clk_sys);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1;
    lba0 = 32'h0000_1234; cnt0 = 6'd3;  buf0 = 8'hA5;
    lba1 = 32'hDEAD_BEEF; cnt1 = 6'd63; buf1 = 8'h3C;
    rd_post[0] = 0; rd_post[1] = 0; wr_post[0] = 0; wr_post[1] = 0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_sd_rd", sd_rd, 1'b0);
    chk("rst_sd_wr", sd_wr, 1'b0);
    chk("rst_lba", sd_lba, 32'd0);
    chk("rst_cnt", sd_blk_cnt, 6'd0);
    chk("rst_grant", grant, 2'b00);
    @(posedge clk_sys); #1 reset = 1'b0;

    // Single read from drive 0: one-cycle issue latency
    push(0, 1'b0, 32'h0000_1234, 6'd3);
    @(posedge clk_sys); #1 rd_post[0]++;
    @(negedge clk_sys);
    chk("lat_before", sd_rd, 1'b0);
    @(negedge clk_sys);
    chk("lat_issue", sd_rd, 1'b1);
    wait_done(1, "t1_done");

    // Both drives after reset: 0 then 1
    pulse_reset(2);
    base = done_cnt;
    push(0, 1'b0, 32'h0000_1234, 6'd3);
    push(1, 1'b0, 32'hDEAD_BEEF, 6'd63);
    @(posedge clk_sys); #1 rd_post[0]++; rd_post[1]++;
    wait_done(base + 2, "t2_done");

    // Drive 0 continuous, drive 1 once: order 0,1,0,0
    pulse_reset(2);
    base = done_cnt;
    hold[0] = 1'b1;
    push(0, 1'b0, 32'h0000_1234, 6'd3);
    push(1, 1'b0, 32'hDEAD_BEEF, 6'd63);
    push(0, 1'b0, 32'h0000_1234, 6'd3);
    push(0, 1'b0, 32'h0000_1234, 6'd3);
    @(posedge clk_sys); #1 rd_post[0]++; rd_post[1]++;
    wait_done(base + 3, "t3_three");
    hold[0] = 1'b0;
    wait_done(base + 4, "t3_done");
    repeat (8) @(negedge clk_sys);

    // Drive 1 read+write: write first, then the read
    pulse_reset(2);
    base = done_cnt;
    push(1, 1'b1, 32'hDEAD_BEEF, 6'd63);
    push(1, 1'b0, 32'hDEAD_BEEF, 6'd63);
    @(posedge clk_sys); #1 rd_post[1]++; wr_post[1]++;
    wait_done(base + 2, "t4_done");

    // Reset during BUSY, then both request: drive 0 must win
    lba0 = 32'hFFFF_FFFF; cnt0 = 6'd0;
    push(0, 1'b0, 32'hFFFF_FFFF, 6'd0);
    @(posedge clk_sys); #1 rd_post[0]++;
    begin
      int c;
      for (c = 0; c < 50 && !sd_ack; c++) @(negedge clk_sys);
      if (!sd_ack) fail_now("t5_ack_wait");
    end
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b1;
    @(posedge clk_sys); #1 reset = 1'b0;
    @(negedge clk_sys);
    chk("t5_sd_rd", sd_rd, 1'b0);
    chk("t5_sd_wr", sd_wr, 1'b0);
    chk("t5_grant", grant, 2'b00);
    chk("t5_req_ack", req_ack, 2'b00);
    begin
      int c;
      for (c = 0; c < 50 && sd_ack; c++) @(negedge clk_sys);
      if (sd_ack) fail_now("t5_ack_drop");
    end
    base = done_cnt;
    push(0, 1'b0, 32'hFFFF_FFFF, 6'd0);
    push(1, 1'b0, 32'hDEAD_BEEF, 6'd63);
    @(posedge clk_sys); #1 rd_post[0]++; rd_post[1]++;
    wait_done(base + 2, "t5_done");

    // Stray ack while idle
    repeat (3) @(posedge clk_sys);
    #1 pulse_req++;
    repeat (6) @(negedge clk_sys);
    chk("t6_sd_rd", sd_rd, 1'b0);
    chk("t6_grant", grant, 2'b00);
    chk("t6_req_ack", req_ack, 2'b00);

    repeat (5) @(negedge clk_sys);
    chk("queue_empty", exp_q.size(), 64'd0);
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule

// File: doc/iecdrv_sd_arb.md
IECDRV_SD_ARB -- requirements
Module: iecdrv_sd_arb

Interface
REQ-001 SHALL have parameter NDRV, default 2, meaning the number of drive requesters sharing one SD block channel (legal range 2..4).
REQ-002 SHALL have port clk_sys  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_lba  input  32*NDRV  per-drive block address; slice i is bits [32i+31:32i].
REQ-005 SHALL have port req_blk_cnt  input  6*NDRV  per-drive block count minus one; slice i is bits [6i+5:6i].
REQ-006 SHALL have port req_rd  input  NDRV  per-drive read request, level, held by the requester until its req_ack rises.
REQ-007 SHALL have port req_wr  input  NDRV  per-drive write request, level, held by the requester until its req_ack rises.
REQ-008 SHALL have port req_buff_din  input  8*NDRV  per-drive write data toward SD.
REQ-009 SHALL have port req_ack  output  NDRV  per-drive acknowledge, routed from sd_ack.
REQ-010 SHALL have port grant  output  NDRV  one-hot owner of the channel; all-zero when idle.
REQ-011 SHALL have port sd_lba  output  32  address to host.
REQ-012 SHALL have port sd_blk_cnt  output  6  count to host.
REQ-013 SHALL have port sd_rd  output  1  host read request.
REQ-014 SHALL have port sd_wr  output  1  host write request.
REQ-015 SHALL have port sd_ack  input  1  host acknowledge, high for the whole transfer.
REQ-016 SHALL have port sd_buff_din  output  8  write data to host.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, BUSY and RELEASE.
REQ-018 In IDLE with pending = req_rd|req_wr nonzero, SHALL select the first pending index scanning from (last+1) mod NDRV, wrapping around.
REQ-019 On that selection SHALL latch the selected index, sd_lba and sd_blk_cnt, set last to the selected index, and enter ISSUE on the next edge.
REQ-020 SHALL, when the selected drive has both req_rd and req_wr high, serve the write only; the read stays pending for a later round.
REQ-021 SHALL register sd_rd/sd_wr so they rise on the same edge that enters ISSUE, one cycle after pending is seen.
REQ-022 SHALL hold sd_rd/sd_wr in ISSUE until sd_ack=1, then clear them on the next edge and enter BUSY.
REQ-023 In BUSY SHALL enter RELEASE on the first edge with sd_ack=0.
REQ-024 RELEASE SHALL last exactly one cycle, then enter IDLE, guaranteeing at least one low cycle of sd_rd/sd_wr between transactions.
REQ-025 SHALL drive req_ack[i] combinationally as sd_ack AND (state is ISSUE or BUSY) AND (selected index == i), with zero latency so it stays aligned with host buffer strobes.
REQ-026 SHALL drive sd_buff_din combinationally as the req_buff_din slice of the selected index; it is 0 in IDLE.
REQ-027 SHALL assert grant[selected] in ISSUE, BUSY and RELEASE, and nothing else.
REQ-028 SHALL keep a transaction running to completion even if the owner drops req_rd/req_wr before sd_ack; no abort path exists.
REQ-029 SHALL ignore requests arriving while not in IDLE; they are served in a later arbitration round.
REQ-030 SHALL ignore an sd_ack pulse while in IDLE or RELEASE: no req_ack is asserted and no state changes.
REQ-031 Round-robin SHALL guarantee that, with all drives requesting continuously, each drive is served once per NDRV transactions.

Reset
REQ-032 While reset=1 SHALL force IDLE, sd_rd=0, sd_wr=0, sd_lba=0, sd_blk_cnt=0, grant=0, and last=NDRV-1 so drive 0 wins first.
REQ-033 Reset mid-transaction SHALL drop sd_rd/sd_wr on the next edge with no RELEASE cycle; req_ack goes 0 on the same cycle because the state is IDLE.

Verification
REQ-034 req_rd=01, req_lba slice0=0x0000_1234, host acks 2 cycles after sd_rd and holds sd_ack 10 cycles -> sd_rd high from cycle+1 until the ack edge, sd_lba=0x1234, req_ack[0] mirrors sd_ack exactly, grant=01, then IDLE 1 cycle after RELEASE.
REQ-035 req_rd=11 asserted together after reset -> drive 0 served first, then drive 1; grant sequence 01 then 10; sd_rd low for at least 1 cycle between the two.
REQ-036 Drive 0 requests continuously while drive 1 requests once -> order is 0,1,0,0 (no starvation).
REQ-037 req_rd[1]=1 and req_wr[1]=1 -> sd_wr=1 and sd_rd=0; after completion with req_wr dropped, a second transaction issues sd_rd.
REQ-038 Reset pulsed for 1 cycle during BUSY -> next cycle: sd_rd=sd_wr=0, grant=0, req_ack=0; a new request is then granted to drive 0.
REQ-039 sd_ack pulsed while IDLE with no requests -> req_ack stays 0 and state stays IDLE.
